// File: rtl/cdb_rr_sched.sv
// cdb_rr_sched: buffered round-robin common-data-bus scheduler.
// Each functional unit has a private result FIFO with a valid/ready
// handshake. Each cycle one non-empty FIFO is popped onto a registered CDB
// output, and a branch mispredict flushes every buffered result.
// Optional build macro: CDB_FIXED_PRIO_EN. When it is defined, the
// lowest-index non-empty FIFO always wins and there is no rr_ptr.

package cdb_rr_sched_pkg;
    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] value;
    } cdb_entry_t;
endpackage

module cdb_rr_sched
    import cdb_rr_sched_pkg::*;
#(
    parameter int NUM_FU    = 2,
    parameter int BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic       [NUM_FU-1:0]   fu_valid,
    input  cdb_entry_t [NUM_FU-1:0]   fu_data,
    output logic       [NUM_FU-1:0]   fu_ready,
    input  logic                      branch_mispredict,
    output logic                      cdb_valid,
    output cdb_entry_t                cdb_out,
    output logic       [NUM_FU-1:0]   grant
);

    localparam int IDX_W = $clog2(NUM_FU);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [NUM_FU-1:0] elig;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    cdb_entry_t        head_data [NUM_FU];

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [NUM_FU-1:0] win_oh;
    cdb_entry_t        head_sel;

    logic              cdb_valid_reg;
    cdb_entry_t        cdb_out_reg;
    logic [NUM_FU-1:0] grant_reg;

    // Per-FU result FIFOs
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fifo
            cdb_entry_t       mem [BUF_DEPTH];
            logic [PTR_W-1:0] wptr_reg;
            logic [PTR_W-1:0] rptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic [PTR_W-1:0] wptr_next;
            logic [PTR_W-1:0] rptr_next;

            // Ready comes from registered occupancy only and is held low
            // during reset. A full FIFO is not ready even when it is popped
            // in the same cycle.
            assign fu_ready[gi] = rst && (count_reg < CNT_W'(BUF_DEPTH));
            assign push[gi]     = fu_valid[gi] && fu_ready[gi] && !branch_mispredict;
            assign elig[gi]     = (count_reg != '0);
            assign head_data[gi] = mem[rptr_reg];

            assign wptr_next = (wptr_reg == PTR_W'(BUF_DEPTH - 1)) ? '0 : wptr_reg + 1'b1;
            assign rptr_next = (rptr_reg == PTR_W'(BUF_DEPTH - 1)) ? '0 : rptr_reg + 1'b1;

            // Pointer and occupancy bookkeeping. A flush clears the FIFO
            // and also drops any push in the same cycle.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                    count_reg <= '0;
                end else if (branch_mispredict) begin
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (push[gi]) wptr_reg <= wptr_next;
                    if (pop[gi])  rptr_reg <= rptr_next;
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Payload storage. It is written only on an accepted handshake.
            always_ff @(posedge clk) begin
                if (push[gi]) mem[wptr_reg] <= fu_data[gi];
            end
        end
    endgenerate

`ifdef CDB_FIXED_PRIO_EN
    // Fixed priority: the lowest-index non-empty FIFO wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W:0]   cand;

    // Round-robin search starts at rr_ptr and wraps through 0. It uses
    // pre-edge occupancy, so there is no same-cycle bypass.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_FU)) cand = cand - (IDX_W + 1)'(NUM_FU);
            if (!win_found && elig[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // rr_ptr moves to the slot after the winner. It keeps its value when
    // there is no grant and across a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_reg <= '0;
        end else if (!branch_mispredict && win_found) begin
            rr_ptr_reg <= (win_idx == IDX_W'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    // One-hot winner and head-entry mux.
    always_comb begin
        win_oh   = '0;
        head_sel = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (win_found && (win_idx == IDX_W'(i))) begin
                win_oh[i] = 1'b1;
                head_sel  = head_data[i];
            end
        end
    end

    assign pop = win_oh;

    // Registered CDB broadcast. Reset takes precedence over flush.
    always_ff @(posedge clk) begin
        if (!rst || branch_mispredict || !win_found) begin
            cdb_valid_reg <= 1'b0;
            cdb_out_reg   <= '0;
            grant_reg     <= '0;
        end else begin
            cdb_valid_reg <= 1'b1;
            cdb_out_reg   <= head_sel;
            grant_reg     <= win_oh;
        end
    end

    assign cdb_valid = cdb_valid_reg;
    assign cdb_out   = cdb_out_reg;
    assign grant     = grant_reg;

endmodule

// File: tb/tb_cdb_rr_sched.sv
// tb_cdb_rr_sched: checks the scheduler with directed scenarios and then
// random traffic against a queue-based reference model (NUM_FU=3, BUF_DEPTH=2).

module tb_cdb_rr_sched;
    import cdb_rr_sched_pkg::*;

    localparam int NF = 3;
    localparam int DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic       [NF-1:0]   fu_valid = '0;
    cdb_entry_t [NF-1:0]   fu_data = '0;
    logic       [NF-1:0]   fu_ready;
    logic                  branch_mispredict = 1'b0;
    logic                  cdb_valid;
    cdb_entry_t            cdb_out;
    logic       [NF-1:0]   grant;

    cdb_rr_sched #(.NUM_FU(NF), .BUF_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .fu_valid          (fu_valid),
        .fu_data           (fu_data),
        .fu_ready          (fu_ready),
        .branch_mispredict (branch_mispredict),
        .cdb_valid         (cdb_valid),
        .cdb_out           (cdb_out),
        .grant             (grant)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference model state
    cdb_entry_t q [NF][$];
    int         rr = 0;
    logic       exp_valid = 1'b0;
    cdb_entry_t exp_data = '0;
    logic [NF-1:0] exp_grant = '0;

    // FU-side sources: each offered entry is held until it is accepted or flushed
    logic [NF-1:0] pend = '0;
    cdb_entry_t    pdata [NF];
    int            seq = 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input logic [NF-1:0] offer, input bit mp);
        logic [NF-1:0] acc;
        int w;
        int idx;
        for (int i = 0; i < NF; i++) begin
            if (!pend[i] && offer[i]) begin
                pend[i]        = 1'b1;
                pdata[i].tag   = 4'(i);
                pdata[i].value = 32'(seq);
                seq++;
            end
        end
        rst = r;
        branch_mispredict = mp;
        for (int i = 0; i < NF; i++) begin
            fu_valid[i] = pend[i];
            fu_data[i]  = pdata[i];
        end
        // Reference model: compute the effect of this clock edge from pre-edge state
        for (int i = 0; i < NF; i++)
            acc[i] = pend[i] && r && !mp && (q[i].size() < DEPTH);
        if (!r || mp) begin
            for (int i = 0; i < NF; i++) q[i].delete();
            if (!r) rr = 0;
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_grant = '0;
        end else begin
            w = -1;
            for (int k = 0; k < NF; k++) begin
`ifdef CDB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (rr + k) % NF;
`endif
                if (w < 0 && q[idx].size() > 0) w = idx;
            end
            if (w >= 0) begin
                exp_data  = q[w].pop_front();
                exp_valid = 1'b1;
                exp_grant = NF'(1) << w;
                rr        = (w + 1) % NF;
            end else begin
                exp_valid = 1'b0;
                exp_data  = '0;
                exp_grant = '0;
            end
            for (int i = 0; i < NF; i++)
                if (acc[i]) q[i].push_back(pdata[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NF; i++)
            if (acc[i] || mp || !r) pend[i] = 1'b0;
        check_val("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
        check_val("cdb_out", 64'(cdb_out), 64'(exp_data));
        check_val("grant", 64'(grant), 64'(exp_grant));
        for (int i = 0; i < NF; i++)
            check_val($sformatf("fu_ready%0d", i), 64'(fu_ready[i]),
                      64'(r && (q[i].size() < DEPTH)));
        $display("t=%0t rst=%0b mp=%0b fu_valid=%b ready=%b cdb_valid=%0b grant=%b tag=%0d val=%0d",
                 $time, r, mp, fu_valid, fu_ready, cdb_valid, grant, cdb_out.tag, cdb_out.value);
    endtask

    initial begin
        for (int i = 0; i < NF; i++) pdata[i] = '0;

        // Reset, then a single push from FU1
        step(0, 3'b000, 0);
        step(0, 3'b000, 0);
        step(1, 3'b010, 0);
        repeat (3) step(1, 3'b000, 0);

        // All three FUs push in the same cycle
        step(1, 3'b111, 0);
        repeat (4) step(1, 3'b000, 0);

        // Continuous pushes from FU0 and FU2
        repeat (8) step(1, 3'b101, 0);
        repeat (4) step(1, 3'b000, 0);

        // Backpressure with all FUs streaming
        repeat (10) step(1, 3'b111, 0);
        repeat (6) step(1, 3'b000, 0);

        // Flush with buffered entries plus a same-cycle FU1 push
        step(1, 3'b001, 0);
        step(1, 3'b101, 0);
        step(1, 3'b001, 0);
        step(1, 3'b010, 1);
        repeat (4) step(1, 3'b000, 0);

        // Wrap-around on FU1
        repeat (5) step(1, 3'b010, 0);
        repeat (3) step(1, 3'b000, 0);

        // Reset mid-stream
        repeat (3) step(1, 3'b111, 0);
        step(0, 3'b000, 0);
        repeat (4) step(1, 3'b000, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) != 0),
                 NF'($urandom_range(0, (1 << NF) - 1)),
                 ($urandom_range(0, 19) == 0));
        end
        repeat (6) step(1, 3'b000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/cdb_rr_sched.md
Name: cdb_rr_sched

Overview:
- Buffered round-robin scheduler for the common data bus.
- Each functional unit pushes completed results (cdb_entry_t) into a small private FIFO through a valid/ready handshake.
- Each cycle the scheduler picks one non-empty FIFO, pops its head and drives it onto a registered CDB output.
- Sits between the FU result ports and the ROB/reservation-station CDB listeners. Replaces drop-on-conflict behaviour with lossless, starvation-free sharing plus flush on branch mispredict.

Parameters:
- NUM_FU, 2, number of requesting functional units (>=2).
- BUF_DEPTH, 2, entries per FU result FIFO (power of two, >=1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- fu_valid  input  [NUM_FU] x 1  FU i presents a result this cycle.
- fu_data  input  [NUM_FU] x cdb_entry_t  result payload from FU i.
- fu_ready  output  [NUM_FU] x 1  FIFO i can accept an entry this cycle.
- branch_mispredict  input  1  flush request.
- cdb_valid  output  1  cdb_out carries a broadcast this cycle.
- cdb_out  output  cdb_entry_t  broadcast entry, registered.
- grant  output  NUM_FU  one-hot index of the source FU for the current cdb_out, registered.

Behaviour:
- Reset (rst==0 at posedge):
  - all FIFO counts and read/write pointers = 0; rr_ptr = 0.
  - cdb_valid = 0, cdb_out = '0, grant = '0.
  - fu_ready is forced 0 while rst==0.
- Ready:
  - fu_ready[i] = (count[i] < BUF_DEPTH) and rst==1.
  - Depends only on registered state; no combinational path from fu_valid or branch_mispredict.
- Enqueue: on posedge, if fu_valid[i] && fu_ready[i] && !branch_mispredict, write fu_data[i] at wptr[i], wptr wraps modulo BUF_DEPTH, count[i]+1.
  - fu_valid while !fu_ready is ignored. The FU must hold its data until the handshake completes.
- Arbitration (combinational, registered result):
  - Eligible FIFOs are count[i] != 0, using pre-edge state. There is no same-cycle bypass.
  - Search starts at index rr_ptr and wraps through NUM_FU-1 then 0. The first eligible FIFO is the winner.
  - On posedge: pop the winner's head into cdb_out, set cdb_valid = 1, set grant = onehot(winner), rptr wraps, count-1.
  - rr_ptr = (winner+1) mod NUM_FU.
  - If no FIFO is eligible: cdb_valid = 0, cdb_out = '0, grant = '0, rr_ptr unchanged.
- Latency: handshake at edge N, earliest broadcast visible after edge N+1 (2 cycles from fu_valid assertion). Throughput is 1 entry/cycle aggregate.
- Simultaneous push and pop on the same FIFO: both occur and count is unchanged. A full FIFO that is popped this cycle still shows fu_ready = 0 this cycle (no pass-through).
- Fairness: a continuously non-empty FIFO is granted at least once every NUM_FU cycles.
- branch_mispredict == 1 at posedge (rst==1):
  - all counts and pointers cleared; the same-cycle enqueue is dropped.
  - no pop occurs; cdb_valid = 0, cdb_out = '0, grant = '0 next cycle.
  - rr_ptr is retained.
  - fu_ready returns to 1 on the following cycle.
- Reset takes precedence over mispredict. Reset mid-stream discards all buffered entries.
- No entry is ever duplicated or reordered within a single FU's stream.

Optional Feature:
- Macro CDB_FIXED_PRIO_EN.
- When defined: the arbiter ignores rr_ptr, and the lowest-index non-empty FIFO always wins. rr_ptr is not implemented and the fairness guarantee is void.
- When undefined: round-robin behaviour as above.
- All other behaviour (buffering, flush, latency, reset) is identical in both builds.

Test Plan (NUM_FU=3, BUF_DEPTH=2 unless noted):
- Reset then single push: rst=0 2 cycles, then fu_valid[1]=1 with payload A for one cycle -> fu_ready all 0 during reset and all 1 after; cdb_valid=1, cdb_out=A, grant=3'b010 exactly 2 cycles after the push; cdb_valid=0 thereafter.
- Round-robin: all three FUs push one entry (A0, B1, C2) in the same cycle, rr_ptr=0 -> broadcasts A0, B1, C2 on three consecutive cycles with grant 001, 010, 100. With CDB_FIXED_PRIO_EN the order is the same; repeat with continuous pushes from FU0 and FU2 -> fixed build starves FU2, RR build alternates 001/100.
- Backpressure: FU0 pushes every cycle while FU1 and FU2 also stream -> count[0] reaches 2, fu_ready[0]=0; no FU0 entry is lost; FU0 outputs appear in push order.
- Mispredict flush: fill FIFO0 with 2 entries and FIFO2 with 1, assert branch_mispredict one cycle together with fu_valid[1] -> next cycle cdb_valid=0 and all fu_ready=1; none of the 4 entries (including FU1's dropped push) is ever broadcast.
- Wrap-around: with BUF_DEPTH=2, push and pop FU1 for 5 cycles -> pointers wrap and the output sequence equals the input sequence exactly.
- Reset mid-stream: assert rst=0 while 2 FIFOs are non-empty and cdb_valid=1 -> next cycle cdb_valid=0, grant=0; after release, no stale entry is broadcast.
